fcvt_pipe: RTL and testbench

Pipelined int↔float conversion unit for the core's FPU execute path. It accepts one `fcvt.s.w` / `fcvt.w.s` request per cycle from the FPU dispatch stage over a valid/ready handshake and computes the result in two registered stages. It returns the result with its destination tag to the writeback arbiter, stalling the whole pipe under backpressure and dropping in-flight work on a pipeline flush.

---
 rtl/fcvt_pipe.sv | 140 ++++++++++++++
 tb/tb_fcvt_pipe.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fcvt_pipe.sv
// fcvt_pipe: two-stage int32<->float32 converter (fcvt.s.w / fcvt.w.s).
// Ports: in_* request (op 0=itof, 1=ftoi), out_* result, flush, busy.
module fcvt_pipe #(
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [31:0]      in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic [31:0]      out_data,
  output logic             busy
);

  typedef struct packed {
    logic             op;
    logic [TAG_W-1:0] tag;
    logic             sgn;
    logic [31:0]      mag;
    logic [4:0]       pos;
    logic [7:0]       exp;
    logic             zero;
    logic             sat;
    logic             nan;
  } s1_t;

  function automatic logic [4:0] lead1(
    input logic [31:0] x
  );
    lead1 = '0;
    for (int i = 0; i < 32; i++)
      if (x[i]) lead1 = 5'(i);
  endfunction

  logic        s1_valid;
  logic        s2_valid;
  s1_t         s1;
  s1_t         d1;
  logic        adv;
  logic [31:0] mag_i;

  assign adv       = !s2_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = s2_valid;
  assign busy      = s1_valid || s2_valid;

  assign mag_i = in_data[31] ? (~in_data + 32'd1)
                             : in_data;

  always_comb begin
    d1     = '0;
    d1.op  = in_op;
    d1.tag = in_tag;
    d1.sgn = in_data[31];
    if (!in_op) begin
      d1.mag = mag_i;
      d1.pos = lead1(mag_i);
    end else begin
      d1.mag  = {8'b0, 1'b1, in_data[22:0]};
      d1.exp  = in_data[30:23];
      d1.zero = in_data[30:23] < 8'd126;
      d1.sat  = in_data[30:23] >= 8'd158;
      d1.nan  = (&in_data[30:23])
             && (|in_data[22:0]);
    end
  end

  // itof: hidden bit moved to bit 31, keep 23
  // fraction bits plus one guard bit.
  logic [4:0]  lsh;
  logic [24:0] n25;
  logic [23:0] frac_r;
  logic [7:0]  expo;
  logic [31:0] ires;

  always_comb begin
    lsh    = 5'd31 - s1.pos;
    n25    = 25'((s1.mag << lsh) >> 7);
    frac_r = {1'b0, n25[23:1]}
           + {23'b0, n25[0]};
    expo   = 8'd127 + {3'b0, s1.pos}
           + {7'b0, frac_r[23]};
    ires   = (s1.mag == 32'd0) ? 32'd0
           : {s1.sgn, expo, frac_r[22:0]};
  end

  // ftoi: mantissa scaled so bit 0 of w is the
  // first fraction bit (the rounding bit).
  logic [7:0]  sh;
  logic [32:0] w;
  logic [32:0] v;
  logic [31:0] fres;

  always_comb begin
    sh = s1.exp - 8'd118;
    w  = 33'(({32'b0, s1.mag} << sh) >> 31);
    v  = {1'b0, w[32:1]} + {32'b0, w[0]};
    unique case (1'b1)
      s1.zero: fres = 32'd0;
      s1.sat: begin
        fres = (s1.sgn && !s1.nan)
             ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
      default: begin
        if (v[32] || v[31])
          fres = s1.sgn ? 32'h8000_0000
                        : 32'h7FFF_FFFF;
        else
          fres = s1.sgn ? (~v[31:0] + 32'd1)
                        : v[31:0];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1       <= '0;
      out_tag  <= '0;
      out_data <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1       <= d1;
      s2_valid <= s1_valid;
      out_tag  <= s1.tag;
      out_data <= s1.op ? fres : ires;
    end
  end

endmodule

// File: tb/tb_fcvt_pipe.sv
// tb_fcvt_pipe: directed bench for fcvt_pipe with a
// scoreboard queue checked by an output monitor.
module tb_fcvt_pipe;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic        in_op;
  logic [5:0]  in_tag;
  logic [31:0] in_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_tag;
  logic [31:0] out_data;
  logic        busy;

  fcvt_pipe #(.TAG_W(6)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_tag(in_tag),
    .in_data(in_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_tag(out_tag), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [5:0]  tag;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t       sb[$];
  int         tests = 0;
  int         fails = 0;
  logic [5:0] ntag = '0;

  task automatic check(input string name,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h",
             name, obs, exp);
    end
  endtask

  exp_t m;
  always @(negedge clk) begin
    if (rstn === 1'b1 && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL unexpected_out: observed tag %h data %h expected none",
               out_tag, out_data);
      end else begin
        m = sb.pop_front();
        check("out_data", out_data, m.data);
        check("out_tag", {26'b0, out_tag}, {26'b0, m.tag});
        if (m.due >= 0)
          check("latency", 32'(cyc), 32'(m.due));
      end
    end
  end

  task automatic send(input logic op,
                      input logic [31:0] d,
                      input logic [31:0] e,
                      input bit lat);
    in_op    = op;
    in_data  = d;
    in_tag   = ntag;
    in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{tag: ntag, data: e,
                       due: lat ? cyc + 2 : -1});
        ntag++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    tests++;
    fails++;
    $error("FAIL send_timeout: observed in_ready 0 expected 1");
    in_valid = 1'b0;
  endtask

  logic [31:0] bp_in  [4] = '{32'd1, 32'd2, 32'd3, 32'd4};
  logic [31:0] bp_exp [4] = '{32'h3F80_0000, 32'h4000_0000,
                              32'h4040_0000, 32'h4080_0000};

  initial begin
    int idx;
    logic [31:0] snap_d;
    logic [5:0]  snap_t;

    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_op     = 1'b0;
    in_tag    = '0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    #12;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_tag", {26'b0, out_tag}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // itof back-to-back
    send(1'b0, 32'd1,         32'h3F80_0000, 1'b1);
    send(1'b0, 32'hFFFF_FFFF, 32'hBF80_0000, 1'b1);
    send(1'b0, 32'd0,         32'h0000_0000, 1'b1);
    send(1'b0, 32'h8000_0000, 32'hCF00_0000, 1'b1);
    send(1'b0, 32'h7FFF_FFFF, 32'h4F00_0000, 1'b1);
    send(1'b0, 32'd16777217,  32'h4B80_0001, 1'b1);

    // ftoi rounding
    send(1'b1, 32'h4020_0000, 32'd3,         1'b1);
    send(1'b1, 32'hC020_0000, 32'hFFFF_FFFD, 1'b1);
    send(1'b1, 32'h3F00_0000, 32'd1,         1'b1);
    send(1'b1, 32'h3EFF_FFFF, 32'd0,         1'b1);
    send(1'b1, 32'h3FC0_0000, 32'd2,         1'b1);
    send(1'b1, 32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b1);

    // ftoi saturation
    send(1'b1, 32'h4F00_0000, 32'h7FFF_FFFF, 1'b1);
    send(1'b1, 32'hCF00_0000, 32'h8000_0000, 1'b1);
    send(1'b1, 32'h7FC0_0000, 32'h7FFF_FFFF, 1'b1);
    send(1'b1, 32'hFF80_0000, 32'h8000_0000, 1'b1);
    send(1'b1, 32'h0000_0001, 32'd0,         1'b1);
    repeat (4) @(posedge clk);
    #1;

    // backpressure
    out_ready = 1'b0;
    idx       = 0;
    snap_d    = '0;
    snap_t    = '0;
    in_op     = 1'b0;
    in_data   = bp_in[0];
    in_tag    = ntag;
    in_valid  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        check("bp_in_ready", {31'b0, in_ready}, 32'd0);
        check("bp_out_valid", {31'b0, out_valid}, 32'd1);
      end
      if (c == 2) begin
        snap_d = out_data;
        snap_t = out_tag;
        check("bp_accepted", 32'(idx), 32'd2);
      end
      if (c > 2) begin
        check("bp_data_stable", out_data, snap_d);
        check("bp_tag_stable", {26'b0, out_tag},
              {26'b0, snap_t});
      end
      if (in_ready && idx < 4) begin
        sb.push_back('{tag: ntag, data: bp_exp[idx], due: -1});
        ntag++;
        idx++;
      end
      @(posedge clk); #1;
      if (idx < 4) begin
        in_data = bp_in[idx];
        in_tag  = ntag;
      end else begin
        in_valid = 1'b0;
      end
    end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{tag: ntag, data: bp_exp[idx], due: -1});
        ntag++;
        idx++;
      end
      @(posedge clk); #1;
      if (idx < 4) begin
        in_data = bp_in[idx];
        in_tag  = ntag;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("bp_all_issued", 32'(idx), 32'd4);
    repeat (4) @(posedge clk);
    #1;
    check("bp_drained", 32'(sb.size()), 32'd0);

    // flush with two entries in flight
    out_ready = 1'b0;
    in_op     = 1'b0;
    in_data   = 32'd7;
    in_tag    = 6'h30;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_data   = 32'd8;
    in_tag    = 6'h31;
    @(posedge clk); #1;
    check("fl_busy_pre", {31'b0, busy}, 32'd1);
    check("fl_out_valid_pre", {31'b0, out_valid}, 32'd1);
    in_data   = 32'd9;
    in_tag    = 6'h32;
    flush     = 1'b1;
    @(posedge clk); #1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    check("fl_out_valid", {31'b0, out_valid}, 32'd0);
    check("fl_busy", {31'b0, busy}, 32'd0);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("fl_still_idle", {31'b0, busy}, 32'd0);

    // async reset with S2 valid
    out_ready = 1'b0;
    send(1'b0, 32'd5, 32'h40A0_0000, 1'b0);
    @(posedge clk); #1;
    check("ar_out_valid_pre", {31'b0, out_valid}, 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    check("ar_out_valid", {31'b0, out_valid}, 32'd0);
    check("ar_busy", {31'b0, busy}, 32'd0);
    check("ar_out_data", out_data, 32'd0);
    sb.delete();
    @(negedge clk); #2;
    rstn      = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(1'b0, 32'd3, 32'h4040_0000, 1'b1);

    for (int c = 0; c < 20 && sb.size() != 0; c++)
      @(negedge clk);
    check("final_drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
